// File: rtl/leaf_pkt_pkg.sv
// leaf_pkt_pkg
//   Shared definitions for the leaf transmit packetizer: BFT packet field
//   offsets, the packet struct and the credit value a port starts with.
//   Packet layout, MSB first: valid | dest leaf | dest port | addr | payload.
package leaf_pkt_pkg;

  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 43;
  localparam int PORT_LSB  = 39;
  localparam int ADDR_LSB  = 32;

  localparam int PKT_LEAF_W    = VALID_BIT - LEAF_LSB;
  localparam int PKT_PORT_W    = LEAF_LSB - PORT_LSB;
  localparam int PKT_ADDR_W    = PORT_LSB - ADDR_LSB;
  localparam int PKT_PAYLOAD_W = ADDR_LSB;

  // A receiver buffer holds 2^addr-bits words, so that is the starting credit.
  localparam int CREDIT_RST = 1 << PKT_ADDR_W;

  typedef struct packed {
    logic                     valid;
    logic [PKT_LEAF_W-1:0]    leaf;
    logic [PKT_PORT_W-1:0]    port;
    logic [PKT_ADDR_W-1:0]    addr;
    logic [PKT_PAYLOAD_W-1:0] payload;
  } pkt_t;

endpackage

// File: rtl/leaf_rr_arbiter.sv
// leaf_rr_arbiter
//   Combinational N-way round-robin arbiter. The search starts at the
//   requester after ptr and wraps, so the last winner has lowest priority.
//   Ports:
//     req     in  N      request vector
//     ptr     in  IDX_W  index of the previous winner
//     gnt     out N      one-hot grant (all zero when nobody requests)
//     gnt_idx out IDX_W  binary index of the granted requester
//     gnt_any out 1      some requester was granted
module leaf_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_packetizer.sv
// leaf_packetizer
//   Transmit-side packetizer of a leaf. Round-robin arbitrates among the
//   user output streams (ap_vld/ap_ack), wraps the granted word into a BFT
//   packet addressed from a per-port destination table and holds it in the
//   output register until the BFT takes it. A port only sends while its
//   destination has credit.
//   Optional build macro: STALL_CNT_EN adds per-port stall counters.
//   Ports:
//     clk_bft                  in  clock
//     reset                    in  synchronous, active-low reset
//     din_leaf_user2interface  in  user words, port i in slice i
//     vld_user2interface       in  per-port ap_vld
//     ack_interface2user       out per-port ap_ack (combinational grant)
//     cfg_wr/sel/leaf/port     in  destination table write
//     credit_upd/credit_sel    in  freespace update for one port
//     dout_leaf_interface2bft  out packet, MSB is valid
//     bft_ready                in  BFT accepts the current packet
//     stall_cnt                out 16-bit stall counter per port (STALL_CNT_EN)
module leaf_packetizer
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk_bft,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]              cfg_sel,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic                                  credit_upd,
  input  logic [NUM_PORT_BITS-1:0]              credit_sel,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  bft_ready
`ifdef STALL_CNT_EN
  ,
  output logic [NUM_OUT_PORTS*16-1:0]           stall_cnt
`endif
);

  localparam int IDX_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CW    = NUM_ADDR_BITS + 1;

  logic                     tbl_vld  [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] tbl_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] tbl_port [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_cnt [NUM_OUT_PORTS];
  logic [CW-1:0]            credit   [NUM_OUT_PORTS];
  logic [IDX_W-1:0]         rr_ptr;

  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] req;
  logic [NUM_OUT_PORTS-1:0] gnt;
  logic [IDX_W-1:0]         gnt_idx;
  logic                     gnt_any;
  logic                     free;

  pkt_t pkt_d;
  pkt_t pkt_p1;

  // Add a freespace update and/or take one credit, clamped to the buffer depth.
  // A grant never happens at zero credit, so the decrement cannot underflow.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic          upd,
                                                input logic          dec);
    logic [CW:0] sum;
    sum = {1'b0, cur};
    if (upd) sum = sum + (CW+1)'(FREESPACE_UPDATE_SIZE);
    if (dec) sum = sum - (CW+1)'(1);
    if (sum > (CW+1)'(CREDIT_RST)) sum = (CW+1)'(CREDIT_RST);
    return sum[CW-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i] = vld_user2interface[i] && tbl_vld[i] && (credit[i] != '0);
    end
  end

  // The register may take a new packet when empty or when the BFT drains it now.
  assign free = !pkt_p1.valid || bft_ready;
  assign req  = free ? elig : '0;

  leaf_rr_arbiter #(
    .N     (NUM_OUT_PORTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign ack_interface2user = gnt;

  always_comb begin
    pkt_d.valid   = 1'b1;
    pkt_d.leaf    = tbl_leaf[gnt_idx];
    pkt_d.port    = tbl_port[gnt_idx];
    pkt_d.addr    = addr_cnt[gnt_idx];
    pkt_d.payload = din_leaf_user2interface[int'(gnt_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  // ---- stage p0 -> p1: grant loads the output register ----
  always_ff @(posedge clk_bft) begin
    if (!reset) begin
      pkt_p1 <= '0;
      rr_ptr <= IDX_W'(NUM_OUT_PORTS - 1);
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        tbl_vld[i]  <= 1'b0;
        addr_cnt[i] <= '0;
        credit[i]   <= CW'(CREDIT_RST);
      end
    end else begin
      if (gnt_any) begin
        pkt_p1 <= pkt_d;
        rr_ptr <= gnt_idx;
      end else if (pkt_p1.valid && bft_ready) begin
        pkt_p1.valid <= 1'b0;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (cfg_wr && cfg_sel == NUM_PORT_BITS'(i)) tbl_vld[i] <= 1'b1;
        if (gnt[i]) addr_cnt[i] <= addr_cnt[i] + NUM_ADDR_BITS'(1);
        credit[i] <= credit_next(credit[i],
                                 credit_upd && credit_sel == NUM_PORT_BITS'(i),
                                 gnt[i]);
      end
    end
  end

  // Table contents are qualified by tbl_vld, so they need no reset.
  always_ff @(posedge clk_bft) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (cfg_wr && cfg_sel == NUM_PORT_BITS'(i)) begin
        tbl_leaf[i] <= cfg_leaf;
        tbl_port[i] <= cfg_port;
      end
    end
  end

  assign dout_leaf_interface2bft = pkt_p1;

`ifdef STALL_CNT_EN
  logic [15:0] stall_q [NUM_OUT_PORTS];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_bft) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!reset) begin
        stall_q[i] <= '0;
      end else if (vld_user2interface[i] && !gnt[i]) begin
        stall_q[i] <= sat_inc16(stall_q[i]);
      end
    end
  end

  always_comb begin
    stall_cnt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      stall_cnt[i*16 +: 16] = stall_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_leaf_packetizer.sv
// tb_leaf_packetizer
//   Directed bench for leaf_packetizer with hand-computed packets.
module tb_leaf_packetizer;

  logic        clk_bft = 1'b0;
  logic        reset;
  logic [63:0] din;
  logic [1:0]  vld;
  logic [1:0]  ack;
  logic        cfg_wr;
  logic [3:0]  cfg_sel;
  logic [4:0]  cfg_leaf;
  logic [3:0]  cfg_port;
  logic        credit_upd;
  logic [3:0]  credit_sel;
  logic [48:0] dout;
  logic        bft_ready;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int n;

  always #5 clk_bft = ~clk_bft;

  leaf_packetizer dut (
    .clk_bft                 (clk_bft),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_wr                  (cfg_wr),
    .cfg_sel                 (cfg_sel),
    .cfg_leaf                (cfg_leaf),
    .cfg_port                (cfg_port),
    .credit_upd              (credit_upd),
    .credit_sel              (credit_sel),
    .dout_leaf_interface2bft (dout),
    .bft_ready               (bft_ready)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt               (stall_cnt)
`endif
  );

  function automatic logic [48:0] mk_pkt(input logic v, input logic [4:0] l,
                                         input logic [3:0] p, input logic [6:0] a,
                                         input logic [31:0] d);
    return {v, l, p, a, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_bft);
    #1;
  endtask

  task automatic configure;
    cfg_wr = 1'b1; cfg_sel = 4'd0; cfg_leaf = 5'd3;  cfg_port = 4'd1;  tick();
    cfg_sel = 4'd1; cfg_leaf = 5'd7;  cfg_port = 4'd2;  tick();
    cfg_sel = 4'd5; cfg_leaf = 5'd31; cfg_port = 4'd15; tick();
    cfg_wr = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0; vld = '0; cfg_wr = 1'b0; credit_upd = 1'b0;
    tick(); tick();
    reset = 1'b1;
    configure();
  endtask

  // Holds the current vld and counts consecutive port-0 acks, bounded by max.
  task automatic run_acks(input int max, output int cnt);
    cnt = 0;
    for (int i = 0; i < max; i++) begin
      #1;
      if (ack[0] !== 1'b1) break;
      cnt++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; din = '0; vld = '0; cfg_wr = 1'b0; cfg_sel = '0; cfg_leaf = '0;
    cfg_port = '0; credit_upd = 1'b0; credit_sel = '0; bft_ready = 1'b1;
    tick(); tick();
    chk("rst_dout", dout, 49'd0);
    vld = 2'b01; din[31:0] = 32'h1;
    #1 chk("rst_ack_unconfigured", ack, 2'b00);
    vld = '0;
    reset = 1'b1;
    configure();

    // single port
    din[31:0] = 32'hDEADBEEF; vld = 2'b01;
    #1 chk("single_ack", ack, 2'b01);
    tick();
    chk("single_pkt", dout, mk_pkt(1'b1, 5'd3, 4'd1, 7'd0, 32'hDEADBEEF));
    vld = '0;
    #1 chk("ack_idle", ack, 2'b00);
    tick();
    chk("valid_clear", dout, mk_pkt(1'b0, 5'd3, 4'd1, 7'd0, 32'hDEADBEEF));

    // both ports: pointer is at 0, so port 1 wins first
    din = {32'hB1B1B1B1, 32'hA0A0A0A0}; vld = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_ack", ack, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      if (k % 2 == 0)
        chk("rr_pkt", dout, mk_pkt(1'b1, 5'd7, 4'd2, 7'(k/2), 32'hB1B1B1B1));
      else
        chk("rr_pkt", dout, mk_pkt(1'b1, 5'd3, 4'd1, 7'(1 + k/2), 32'hA0A0A0A0));
    end

    // backpressure
    bft_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("stall_ack", ack, 2'b00);
      tick();
      chk("stall_hold", dout, mk_pkt(1'b1, 5'd3, 4'd1, 7'd2, 32'hA0A0A0A0));
    end
    bft_ready = 1'b1;
    #1 chk("resume_ack", ack, 2'b10);
    tick();
    chk("resume_pkt", dout, mk_pkt(1'b1, 5'd7, 4'd2, 7'd2, 32'hB1B1B1B1));
    vld = '0;
    tick();

    // credit exhaustion and address wrap on port 0
    do_reset();
    vld = 2'b01; n = 0;
    for (int i = 0; i < 128; i++) begin
      din[31:0] = 32'(i);
      #1;
      if (ack == 2'b01) n++;
      tick();
    end
    chk("burst_acks", 64'(n), 64'd128);
    chk("burst_last", dout, mk_pkt(1'b1, 5'd3, 4'd1, 7'd127, 32'd127));
    din[31:0] = 32'h77;
    #1 chk("no_credit_ack", ack, 2'b00);
    tick();
    chk("no_credit_drain", dout, mk_pkt(1'b0, 5'd3, 4'd1, 7'd127, 32'd127));
    credit_upd = 1'b1; credit_sel = 4'd0;
    #1 chk("upd_cycle_ack", ack, 2'b00);
    tick();
    credit_upd = 1'b0; din[31:0] = 32'h55;
    #1 chk("credit_resume_ack", ack, 2'b01);
    tick();
    chk("addr_wrap", dout, mk_pkt(1'b1, 5'd3, 4'd1, 7'd0, 32'h55));
    vld = '0;
    tick();

    // update at full credit saturates at 128
    do_reset();
    credit_upd = 1'b1; credit_sel = 4'd0;
    tick();
    credit_upd = 1'b0; vld = 2'b01;
    run_acks(300, n);
    chk("sat_at_max", 64'(n), 64'd128);
    vld = '0;
    tick();

    // update and grant on the same port at credit 10 -> 73
    do_reset();
    vld = 2'b01;
    run_acks(118, n);
    chk("drain_to_10", 64'(n), 64'd118);
    credit_upd = 1'b1; credit_sel = 4'd0;
    #1 chk("upd_with_grant", ack, 2'b01);
    tick();
    credit_upd = 1'b0;
    run_acks(300, n);
    chk("net_credit", 64'(n), 64'd73);
    vld = '0;
    tick();

    // reset with a packet pending
    din[63:32] = 32'hC3C3C3C3; vld = 2'b10; bft_ready = 1'b0;
    #1 chk("pend_ack", ack, 2'b10);
    tick();
    chk("pend_pkt", dout, mk_pkt(1'b1, 5'd7, 4'd2, 7'd0, 32'hC3C3C3C3));
    reset = 1'b0;
    tick();
    chk("rst_mid_dout", dout, 49'd0);
    #1 chk("rst_mid_ack", ack, 2'b00);
    reset = 1'b1; bft_ready = 1'b1;
    #1 chk("unconf_ack", ack, 2'b00);
    tick();
    chk("unconf_dout", dout, 49'd0);
    vld = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/leaf_packetizer.md
Name: leaf_packetizer

Overview:
- Transmit-side packetizer for a leaf.
- Accepts NUM_OUT_PORTS user output streams using the HLS ap_vld/ap_ack handshake and round-robin arbitrates among them.
- Wraps each word into a BFT packet addressed from a per-port destination table and drives it toward the BFT. Packets leave only while the destination has credit.
- Sits between the user kernel's Output_* streams and the BFT egress; it is the counterpart of the leaf depacketizer/receiver.

Parameters:
- PACKET_BITS, 49, packet width.
- PAYLOAD_BITS, 32, user word width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, per-port write-address field width; also sets receiver buffer depth.
- NUM_OUT_PORTS, 2, number of user output streams.
- FREESPACE_UPDATE_SIZE, 64, credits returned per freespace update.

Ports:
- clk_bft  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-low reset.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words; port i occupies slice i.
- vld_user2interface  in  NUM_OUT_PORTS  per-port ap_vld.
- ack_interface2user  out  NUM_OUT_PORTS  per-port ap_ack.
- cfg_wr  in  1  destination table write strobe.
- cfg_sel  in  NUM_PORT_BITS  table entry index.
- cfg_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_port  in  NUM_PORT_BITS  destination port.
- credit_upd  in  1  freespace update strobe.
- credit_sel  in  NUM_PORT_BITS  port receiving credit.
- dout_leaf_interface2bft  out  PACKET_BITS  packet; MSB is the valid bit.
- bft_ready  in  1  BFT accepts the current packet.

Behaviour:
- Packet layout, MSB first:
  - [48] valid
  - [47:43] dest leaf
  - [42:39] dest port
  - [38:32] addr
  - [31:0] payload
- Reset (reset==0 at a clock edge):
  - dout all zeros; ack all 0.
  - Credits = 2^NUM_ADDR_BITS (128).
  - addr counters = 0; table entries invalid; rr pointer = NUM_OUT_PORTS-1.
- Destination table:
  - cfg_wr writes leaf/port into entry cfg_sel and marks it valid.
  - cfg_sel >= NUM_OUT_PORTS is ignored.
  - A write lands at the clock edge; the new entry takes effect for grants from the next cycle.
- Eligibility: port i is eligible when vld[i]==1, its entry is valid, and credit[i] > 0.
- Output register:
  - "free" = (dout[48]==0) OR bft_ready.
  - A packet is consumed at an edge where dout[48]==1 and bft_ready==1.
  - When consumed with no new grant, dout[48] clears to 0.
  - When not consumed, dout holds stable.
- Grant:
  - Issued when free and at least one port is eligible.
  - Round-robin: search starts at rr+1 modulo NUM_OUT_PORTS.
  - ack[grant]=1 combinationally in the same cycle; at most one ack bit high at a time.
  - At the next edge:
    - dout loads the packet with valid=1.
    - addr[grant] increments (wraps 127->0).
    - credit[grant] decrements.
    - rr = grant.
  - Latency: vld to ack is 0 cycles; vld to packet is 1 cycle.
  - Throughput: 1 packet per cycle when bft_ready is held high.
- Credits:
  - credit_upd adds FREESPACE_UPDATE_SIZE to credit[credit_sel], saturating at 128.
  - If an update and a grant hit the same port in one cycle, net change = +64 - 1, then saturate.
  - At credit 0 the port is skipped; vld stays high and data stays held by the user, per the HLS protocol.
- ack never depends on vld of another port beyond arbitration. ack is 0 whenever vld is 0.
- Reset mid-operation: an in-flight packet in dout is dropped. Credits, addresses, and the table return to reset values.

Optional Feature:
- STALL_CNT_EN defined:
  - Adds output stall_cnt, NUM_OUT_PORTS*16 bits.
  - Per-port counter increments each cycle vld[i]==1 and ack[i]==0; saturates at 0xFFFF; cleared by reset.
- STALL_CNT_EN undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package leaf_pkt_pkg holds:
  - field offsets/widths (VALID_BIT=48, LEAF_LSB=43, PORT_LSB=39, ADDR_LSB=32);
  - a packet struct typedef;
  - the reset credit constant.
- One sub-module: leaf_rr_arbiter, a parameterized N-way round-robin arbiter with request, pointer, and one-hot grant.

Test Plan:
- Single port: set table port0 = leaf 3 / port 1. Assert vld0 with 0xDEADBEEF, bft_ready=1.
  -> ack0 high same cycle; next cycle dout = {1, 5'd3, 4'd1, 7'd0, 32'hDEADBEEF}.
- Both ports continuously valid, bft_ready=1.
  -> grants alternate 0,1,0,1; addr fields count 0,0,1,1,2,...
- bft_ready=0 for 5 cycles after the first packet.
  -> dout holds unchanged; ack stays 0; the next packet appears one cycle after bft_ready rises.
- Send 128 words on port0 with no updates.
  -> the 129th vld gets no ack. Pulse credit_upd for port0: ack resumes next cycle; the addr field has wrapped to 0.
- In one cycle, credit_upd and a grant both target port0 with credit 10.
  -> credit becomes 73. At credit 128, an update leaves it at 128.
- Assert reset while a packet is pending.
  -> dout=0 and ack=0 the next cycle; an unconfigured port with vld=1 gets no ack.
